// File: rtl/buzzer_sfx.sv
// buzzer_sfx: jump beep and three-tone game-over jingle driving an active-low buzzer.
// Optional macro SFX_DUTY25_EN: 25% duty tone (quieter, same pitch); default is 50% duty.
module buzzer_sfx #(
   parameter int CLK_HZ     = 100000000,
   parameter int JUMP_HALF  = 50000,
   parameter int JUMP_MS    = 60,
   parameter int OVER_HALF1 = 100000,
   parameter int OVER_HALF2 = 125000,
   parameter int OVER_HALF3 = 166667,
   parameter int OVER_MS    = 150,
   parameter int GAP_MS     = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] jump,
   input  logic       gameover,
   input  logic       pause,
   output logic       buzzer,
   output logic       busy
);
   localparam int TICK     = CLK_HZ / 1000;
   localparam int MAX_H12  = (OVER_HALF1 > OVER_HALF2) ? OVER_HALF1 : OVER_HALF2;
   localparam int MAX_H3J  = (OVER_HALF3 > JUMP_HALF) ? OVER_HALF3 : JUMP_HALF;
   localparam int MAX_HALF = (MAX_H12 > MAX_H3J) ? MAX_H12 : MAX_H3J;
   localparam int MAX_CNT  = (MAX_HALF > TICK) ? MAX_HALF : TICK;
   localparam int CW       = $clog2(MAX_CNT + 1);
   localparam int MAX_MS0  = (JUMP_MS > OVER_MS) ? JUMP_MS : OVER_MS;
   localparam int MAX_MS   = (MAX_MS0 > GAP_MS) ? MAX_MS0 : GAP_MS;
   localparam int DW       = $clog2(MAX_MS + 1);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] JMP  = 3'd1;
   localparam logic [2:0] OV1  = 3'd2;
   localparam logic [2:0] GAP1 = 3'd3;
   localparam logic [2:0] OV2  = 3'd4;
   localparam logic [2:0] GAP2 = 3'd5;
   localparam logic [2:0] OV3  = 3'd6;

   function automatic logic [CW-1:0] half_of(input logic [2:0] s);
      case (s)
         JMP:     half_of = CW'(JUMP_HALF);
         OV1:     half_of = CW'(OVER_HALF1);
         OV2:     half_of = CW'(OVER_HALF2);
         OV3:     half_of = CW'(OVER_HALF3);
         default: half_of = '0;
      endcase
   endfunction

   function automatic logic [DW-1:0] ms_of(input logic [2:0] s);
      case (s)
         JMP:           ms_of = DW'(JUMP_MS);
         OV1, OV2, OV3: ms_of = DW'(OVER_MS);
         GAP1, GAP2:    ms_of = DW'(GAP_MS);
         default:       ms_of = '0;
      endcase
   endfunction

   function automatic logic is_tone(input logic [2:0] s);
      is_tone = (s == JMP) || (s == OV1) || (s == OV2) || (s == OV3);
   endfunction

   function automatic logic [2:0] succ_of(input logic [2:0] s);
      case (s)
         OV1:     succ_of = GAP1;
         GAP1:    succ_of = OV2;
         OV2:     succ_of = GAP2;
         GAP2:    succ_of = OV3;
         default: succ_of = IDLE;
      endcase
   endfunction

   logic [2:0]    state_reg, state_next;
   logic [CW-1:0] ms_cnt_reg, ms_cnt_next;
   logic [CW-1:0] tone_cnt_reg, tone_cnt_next;
   logic          phase_reg, phase_next;
   logic [DW-1:0] dur_reg, dur_next;
   logic          jump_prev_reg, over_prev_reg;
   logic          buzzer_reg, busy_reg;
   logic          jump_evt, over_evt, ms_tick, done, enter, sound;
   logic [2:0]    target;
`ifdef SFX_DUTY25_EN
   logic [CW-1:0] half_next;
`endif

   always_comb begin
      jump_evt = (|jump) & ~jump_prev_reg;
      over_evt = gameover & ~over_prev_reg;
      ms_tick  = (ms_cnt_reg == CW'(TICK - 1));
      done     = ms_tick && (dur_reg == ms_of(state_reg) - DW'(1));

      // Events outrank the duration expiry; game over outranks everything.
      enter  = 1'b0;
      target = state_reg;
      if (over_evt) begin
         enter  = 1'b1;
         target = OV1;
      end else if (jump_evt && (state_reg == IDLE || state_reg == JMP)) begin
         enter  = 1'b1;
         target = JMP;
      end else if (state_reg != IDLE && done) begin
         enter  = 1'b1;
         target = succ_of(state_reg);
      end

      state_next    = state_reg;
      ms_cnt_next   = ms_cnt_reg;
      tone_cnt_next = tone_cnt_reg;
      phase_next    = phase_reg;
      dur_next      = dur_reg;
      if (!pause) begin
         if (enter) begin
            state_next    = target;
            ms_cnt_next   = '0;
            tone_cnt_next = '0;
            phase_next    = 1'b0;
            dur_next      = '0;
         end else if (state_reg != IDLE) begin
            ms_cnt_next = ms_tick ? '0 : ms_cnt_reg + CW'(1);
            if (ms_tick)
               dur_next = dur_reg + DW'(1);
            if (is_tone(state_reg)) begin
               if (tone_cnt_reg == half_of(state_reg) - CW'(1)) begin
                  tone_cnt_next = '0;
                  phase_next    = ~phase_reg;
               end else begin
                  tone_cnt_next = tone_cnt_reg + CW'(1);
               end
            end
         end
      end

`ifdef SFX_DUTY25_EN
      half_next = half_of(state_next);
      sound     = is_tone(state_next) && !phase_next && (tone_cnt_next < (half_next >> 1));
`else
      sound     = is_tone(state_next) && !phase_next;
`endif
   end

   // Buzzer is computed from next-state values so it lines up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         ms_cnt_reg    <= '0;
         tone_cnt_reg  <= '0;
         phase_reg     <= 1'b0;
         dur_reg       <= '0;
         jump_prev_reg <= 1'b0;
         over_prev_reg <= 1'b0;
         buzzer_reg    <= 1'b1;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         ms_cnt_reg    <= ms_cnt_next;
         tone_cnt_reg  <= tone_cnt_next;
         phase_reg     <= phase_next;
         dur_reg       <= dur_next;
         jump_prev_reg <= |jump;
         over_prev_reg <= gameover;
         buzzer_reg    <= pause | ~sound;
         busy_reg      <= (state_next != IDLE);
      end
   end

   assign buzzer = buzzer_reg;
   assign busy   = busy_reg;
endmodule

// File: tb/tb_buzzer_sfx.sv
// Bench for buzzer_sfx: directed scenarios plus random events, checked against an
// effect-timeline model (segment + elapsed clocks) and explicit effect-length constants.
`timescale 1ns/1ps
module tb_buzzer_sfx;
   localparam int CLK_HZ     = 10000;
   localparam int JUMP_HALF  = 2;
   localparam int JUMP_MS    = 3;
   localparam int OVER_HALF1 = 2;
   localparam int OVER_HALF2 = 3;
   localparam int OVER_HALF3 = 4;
   localparam int OVER_MS    = 2;
   localparam int GAP_MS     = 1;
   localparam int TICK       = CLK_HZ / 1000;

   localparam int S_IDLE = 0, S_JMP = 1, S_OV1 = 2, S_GAP1 = 3, S_OV2 = 4, S_GAP2 = 5, S_OV3 = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] jump;
   logic       gameover;
   logic       pause;
   logic       buzzer;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int busy_cnt = 0;

   // Effect timeline: segment lengths in clocks, tone half-periods (0 = silent), successor.
   int seg_len   [7] = '{0, JUMP_MS*TICK, OVER_MS*TICK, GAP_MS*TICK, OVER_MS*TICK, GAP_MS*TICK, OVER_MS*TICK};
   int seg_half  [7] = '{0, JUMP_HALF, OVER_HALF1, 0, OVER_HALF2, 0, OVER_HALF3};
   int seg_after [7] = '{S_IDLE, S_IDLE, S_GAP1, S_OV2, S_GAP2, S_OV3, S_IDLE};
   int   seg, el;
   bit   pj, po;
   logic exp_buz, exp_busy;

   buzzer_sfx #(
      .CLK_HZ(CLK_HZ), .JUMP_HALF(JUMP_HALF), .JUMP_MS(JUMP_MS),
      .OVER_HALF1(OVER_HALF1), .OVER_HALF2(OVER_HALF2), .OVER_HALF3(OVER_HALF3),
      .OVER_MS(OVER_MS), .GAP_MS(GAP_MS)
   ) dut (
      .clk(clk), .reset(reset), .jump(jump), .gameover(gameover),
      .pause(pause), .buzzer(buzzer), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      seg = S_IDLE; el = 0; pj = 1'b0; po = 1'b0;
      exp_buz = 1'b1; exp_busy = 1'b0;
   endtask

   task automatic model_edge();
      bit jev, oev;
      int low;
      if (reset) begin
         model_reset();
         return;
      end
      jev = (jump != 5'd0) && !pj;
      oev = gameover && !po;
      pj  = (jump != 5'd0);
      po  = gameover;
      if (!pause) begin
         if (oev) begin
            seg = S_OV1; el = 0;
         end else if (jev && (seg == S_IDLE || seg == S_JMP)) begin
            seg = S_JMP; el = 0;
         end else if (seg != S_IDLE) begin
            el++;
            if (el == seg_len[seg]) begin
               seg = seg_after[seg]; el = 0;
            end
         end
      end
      exp_busy = (seg != S_IDLE);
      exp_buz  = 1'b1;
      if (!pause && seg_half[seg] != 0) begin
`ifdef SFX_DUTY25_EN
         low = seg_half[seg] / 2;
`else
         low = seg_half[seg];
`endif
         exp_buz = ((el % (2 * seg_half[seg])) < low) ? 1'b0 : 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("buzzer", {31'b0, buzzer}, {31'b0, exp_buz});
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      if (busy === 1'b1) busy_cnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic async_reset_check(input string tag);
      #2 reset = 1'b1;
      #1;
      check({tag, "_buz"}, {31'b0, buzzer}, 32'd1);
      check({tag, "_busy"}, {31'b0, busy}, 32'd0);
      model_reset();
   endtask

   initial begin
      reset = 1'b1; jump = 5'd0; gameover = 1'b0; pause = 1'b0;
      model_reset();
      #1;
      check("rst_buz", {31'b0, buzzer}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      run(3);
      reset = 1'b0;
      busy_cnt = 0;
      run(20);
      check("idle_len", busy_cnt, 0);

      // single jump beep
      busy_cnt = 0;
      jump = 5'd3; step(); jump = 5'd0;
      run(39);
      check("jump_len", busy_cnt, 30);

      // game over held high: one jingle, no retrigger
      busy_cnt = 0;
      gameover = 1'b1; step();
      run(119);
      check("over_len", busy_cnt, 80);
      gameover = 1'b0; step();

      // jump on the 15th clock of a beep restarts it
      busy_cnt = 0;
      jump = 5'd3; step(); jump = 5'd0;
      run(14);
      jump = 5'd17; step(); jump = 5'd0;
      run(50);
      check("restart_len", busy_cnt, 45);

      // jumps during the jingle are ignored
      busy_cnt = 0;
      gameover = 1'b1; step();
      run(9);
      jump = 5'd3; step(); jump = 5'd0;
      run(40);
      jump = 5'd1; step(); jump = 5'd0;
      run(40);
      check("jingle_jump_len", busy_cnt, 80);
      gameover = 1'b0; step();

      // pause for 50 clocks inside OV2
      busy_cnt = 0;
      gameover = 1'b1; step();
      run(34);
      pause = 1'b1; run(50); pause = 1'b0;
      run(60);
      check("pause_len", busy_cnt, 130);
      gameover = 1'b0; step();

      // simultaneous jump and game over: jingle wins
      busy_cnt = 0;
      jump = 5'd3; gameover = 1'b1; step(); jump = 5'd0;
      run(89);
      check("simul_len", busy_cnt, 80);
      gameover = 1'b0; step();

      // simultaneous start, then reset mid-OV1
      jump = 5'd5; gameover = 1'b1; step(); jump = 5'd0;
      run(7);
      async_reset_check("midrst");
      gameover = 1'b0;
      run(2);
      reset = 1'b0;
      busy_cnt = 0;
      run(30);
      check("post_rst_busy", busy_cnt, 0);

      // random events
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0)
            jump = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         if ($urandom_range(0, 99) < 3) gameover = ~gameover;
         if ($urandom_range(0, 39) == 0) pause = ~pause;
         step();
      end
      jump = 5'd0; gameover = 1'b0; pause = 1'b0;
      run(100);
      check("final_idle_busy", {31'b0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
